// File: rtl/uart_rx_fifo_if.sv
// CPU-side read port and serial input of uart_rx_fifo, bundled for the IO page decode.
// The testbench or IO decode drives through master; the receiver uses slave.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 8
);
  logic                     rx;
  logic                     rd_pop;
  logic                     clr_err;
  logic [7:0]               rd_data;
  logic                     rd_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     overrun;
  logic                     frame_err;

  modport master (
    output rx, rd_pop, clr_err,
    input  rd_data, rd_valid, count, overrun, frame_err
  );

  modport slave (
    input  rx, rd_pop, clr_err,
    output rd_data, rd_valid, count, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead receive buffer with sticky overrun/frame flags.
// Define UART_RX_FIFO_EN for a DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_rx_fifo #(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic         clk,
  input  logic         resetn,
  uart_rx_fifo_if.slave bus
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CNTW = $clog2(CPB);
  localparam int CW   = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_EN
  localparam int AW   = $clog2(DEPTH);
  localparam int CAP  = DEPTH;
`else
  localparam int CAP  = 1;
`endif
  localparam logic [CNTW-1:0] HALF_M1 = CNTW'(HALF - 1);
  localparam logic [CNTW-1:0] CPB_M1  = CNTW'(CPB - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              sync1_q, sync2_q;
  logic              rx_s;
  logic              push_s, ferr_set_s;
  logic              pop_ok_s, push_ok_s, full_s;
  logic [CW-1:0]     count_q;
  logic              overrun_q, frame_err_q;
  logic [7:0]        head_s;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // One counter times every sample point; it restarts at each sample so that
  // IDLE is re-entered on the stop sample and a back-to-back start is not missed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNTW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
        else       state_d = S_IDLE;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? S_STOP : S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_BREAK;
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
        else      state_d = S_BREAK;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    if (state_q == S_STOP && cnt_q == CPB_M1) begin
      push_s     = rx_s;
      ferr_set_s = !rx_s;
    end else begin
      push_s     = 1'b0;
      ferr_set_s = 1'b0;
    end
  end

  // A pop frees the head slot in the same cycle, so a push at full still fits.
  assign full_s    = (count_q == CW'(CAP));
  assign pop_ok_s  = bus.rd_pop && (count_q != '0);
  assign push_ok_s = push_s && (!full_s || pop_ok_s);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push_s && !push_ok_s) overrun_q <= 1'b1;
      else if (bus.clr_err)     overrun_q <= 1'b0;
      if (ferr_set_s)           frame_err_q <= 1'b1;
      else if (bus.clr_err)     frame_err_q <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= shift_q;
  end

  assign head_s = mem_q[rd_ptr_q];
`else
  logic [7:0] hold_q;

  always_ff @(posedge clk) begin
    if (!resetn)        hold_q <= 8'h00;
    else if (push_ok_s) hold_q <= shift_q;
  end

  assign head_s = hold_q;
`endif

  assign bus.rd_data   = (count_q != '0) ? head_s : 8'h00;
  assign bus.rd_valid  = (count_q != '0);
  assign bus.count     = count_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=16; expectations adapt to UART_RX_FIFO_EN.
module tb_uart_rx_fifo;
  localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_rx_fifo_if #(.DEPTH(8)) bus();

  uart_rx_fifo #(.CLK_FREQ(16), .BAUD(1), .DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Bits are changed on falling edges, CPB cycles each.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pop_one;
    bus.rd_pop = 1'b1;
    @(negedge clk);
    bus.rd_pop = 1'b0;
  endtask

  task automatic test_reset;
    bus.rx = 1'b1; bus.rd_pop = 1'b0; bus.clr_err = 1'b0;
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if ({bus.overrun, bus.frame_err} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {bus.overrun, bus.frame_err}); end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Edge 1 is the first to register the low rx; push lands 2+8+9*16 edges later.
  task automatic test_latency;
    int   n = 0;
    logic seen = 1'b0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        while (!seen && n < 200) begin
          @(posedge clk); #1;
          n++;
          seen = bus.rd_valid;
        end
      end
    join
    n_cmp++; if (!seen || n != 155) begin n_bad++; $display("FAIL latency: got edge %0d (seen=%b) want 155", n, seen); end
    n_cmp++; if (bus.rd_data !== 8'h55) begin n_bad++; $display("FAIL lat_data: got %h want 55", bus.rd_data); end
    n_cmp++; if (bus.count !== 4'd1) begin n_bad++; $display("FAIL lat_count: got %0d want 1", bus.count); end
    pop_one();
    n_cmp++; if ({bus.rd_valid, bus.rd_data, bus.count} !== {1'b0, 8'h00, 4'd0}) begin n_bad++; $display("FAIL lat_pop: got v=%b d=%h c=%0d want v=0 d=00 c=0", bus.rd_valid, bus.rd_data, bus.count); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h01; exp_b[1] = 8'h80; exp_b[2] = 8'hFF; exp_b[3] = 8'h00;
    fork
      for (int k = 0; k < 4; k++) send_frame(exp_b[k], 1'b1);
      for (int k = 0; k < 4; k++) begin
        int w = 0;
        while (!bus.rd_valid && w < 400) begin @(negedge clk); w++; end
        n_cmp++; if (!bus.rd_valid || bus.rd_data !== exp_b[k]) begin n_bad++; $display("FAIL b2b_byte%0d: got v=%b d=%h want v=1 d=%h", k, bus.rd_valid, bus.rd_data, exp_b[k]); end
        pop_one();
      end
    join
    repeat (4) @(negedge clk);
    n_cmp++; if ({bus.frame_err, bus.overrun, bus.count} !== {2'b00, 4'd0}) begin n_bad++; $display("FAIL b2b_end: got fe=%b ov=%b c=%0d want 0 0 0", bus.frame_err, bus.overrun, bus.count); end
  endtask

  task automatic test_glitch;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_cmp++; if ({bus.rd_valid, bus.count, bus.frame_err, bus.overrun} !== {1'b0, 4'd0, 2'b00}) begin n_bad++; $display("FAIL glitch: got v=%b c=%0d fe=%b ov=%b want all 0", bus.rd_valid, bus.count, bus.frame_err, bus.overrun); end
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++; if ({bus.rd_data, bus.count} !== {8'hA5, 4'd1}) begin n_bad++; $display("FAIL glitch_next: got d=%h c=%0d want A5 1", bus.rd_data, bus.count); end
    pop_one();
  endtask

  task automatic test_break;
    send_frame(8'hE7, 1'b0);
    repeat (CPB) @(negedge clk);
    n_cmp++; if ({bus.frame_err, bus.count} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL break_set: got fe=%b c=%0d want 1 0", bus.frame_err, bus.count); end
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL break_clr: got %b want 0", bus.frame_err); end
    repeat (38 * CPB) @(negedge clk);
    n_cmp++; if ({bus.frame_err, bus.count} !== {1'b0, 4'd0}) begin n_bad++; $display("FAIL break_hold: got fe=%b c=%0d want 0 0", bus.frame_err, bus.count); end
    bus.rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++; if ({bus.rd_data, bus.count, bus.frame_err} !== {8'h3C, 4'd1, 1'b0}) begin n_bad++; $display("FAIL break_next: got d=%h c=%0d fe=%b want 3C 1 0", bus.rd_data, bus.count, bus.frame_err); end
    pop_one();
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++; if ({bus.count, bus.overrun} !== {4'(CAP), 1'b1}) begin n_bad++; $display("FAIL ovr_state: got c=%0d ov=%b want %0d 1", bus.count, bus.overrun, CAP); end
    for (int i = 0; i < CAP; i++) begin
      n_cmp++; if (bus.rd_data !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL ovr_pop%0d: got %h want %h", i, bus.rd_data, 8'(8'h10 + i)); end
      pop_one();
    end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_empty: got %b want 0", bus.rd_valid); end
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr: got %b want 0", bus.overrun); end
  endtask

  // Push edge is 154.5 cycles after the frame starts on a falling edge.
  task automatic test_full_pop;
    for (int i = 0; i < CAP; i++) send_frame(8'(8'h20 + i), 1'b1);
    fork
      send_frame(8'(8'h20 + CAP), 1'b1);
      begin
        repeat (154) @(negedge clk);
        bus.rd_pop = 1'b1;
        @(negedge clk);
        bus.rd_pop = 1'b0;
        n_cmp++; if (bus.count !== 4'(CAP)) begin n_bad++; $display("FAIL fullpop_count: got %0d want %0d", bus.count, CAP); end
      end
    join
    n_cmp++; if ({bus.count, bus.overrun} !== {4'(CAP), 1'b0}) begin n_bad++; $display("FAIL fullpop_state: got c=%0d ov=%b want %0d 0", bus.count, bus.overrun, CAP); end
    for (int i = 0; i < CAP; i++) begin
      n_cmp++; if (bus.rd_data !== 8'(8'h21 + i)) begin n_bad++; $display("FAIL fullpop_data%0d: got %h want %h", i, bus.rd_data, 8'(8'h21 + i)); end
      pop_one();
    end
    n_cmp++; if (bus.count !== 4'd0) begin n_bad++; $display("FAIL fullpop_empty: got %0d want 0", bus.count); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_full_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
